lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
// - EX-stage load/store unit. Consumes the lsu_req/lsu_we/lsu_operate controls that the ID/EX register
//   presents to EX, plus the ALU-computed address and the rs2 store data.
// - Runs one data-memory bus transaction per request (req/gnt then rvalid), with byte enables and
//   store-data replication; aligns and sign/zero-extends load data. Stalls the pipeline while busy.
// PARAMETERS
// - DATA_W          32  data/address width; only 32 supported
// - CHECK_MISALIGN  1   1: misaligned accesses raise lsu_err_o, no bus traffic; 0: low addr bits ignored
// PORTS
// - clk_i            in   1   clock, all flops on posedge
// - rst_ni           in   1   asynchronous active-low reset
// - lsu_req_i        in   1   EX holds a memory instruction
// - lsu_we_i         in   1   1 = store
// - lsu_operate_i    in   lsu_opt_e  LSU_LB/LH/LW/LBU/LHU/SB/SH/SW/NONE
// - lsu_addr_i       in   32  effective byte address from ALU
// - lsu_wdata_i      in   32  rs2 data for stores
// - lsu_rd_addr_i    in   5   load destination register
// - data_req_o       out  1   bus request, held until data_gnt_i
// - data_gnt_i       in   1   bus grant
// - data_we_o        out  1   bus write enable
// - data_be_o        out  4   byte enables
// - data_addr_o      out  32  word-aligned address {addr[31:2],2'b00}
// - data_wdata_o     out  32  replicated store data
// - data_rvalid_i    in   1   read/write response valid
// - data_rdata_i     in   32  raw read word
// - data_err_i       in   1   bus error, qualified by data_rvalid_i
// - lsu_busy_o       out  1   stall for IF/ID/ID-EX (combinational)
// - lsu_done_o       out  1   one-cycle pulse: access finished (OK or error)
// - lsu_rdata_o      out  32  extended load result, valid with lsu_done_o on loads
// - lsu_rd_addr_o    out  5   captured rd, valid with lsu_done_o
// - lsu_err_o        out  1   one-cycle pulse: misaligned or bus error
// BEHAVIOUR
// - Reset: state IDLE; every output 0 (data_be_o=4'h0, lsu_rdata_o=0, lsu_rd_addr_o=0).
// - FSM IDLE -> REQ -> (store: IDLE | load: RVALID -> IDLE). Stores also wait in RVALID when bus
//   responds; a store is complete at gnt+rvalid (one response per gnt, both directions).
//   Corrected rule: every transaction goes REQ -> RVALID -> IDLE.
// - IDLE: lsu_req_i && op!=LSU_NONE is accepted. Capture op, we, addr[1:0], rd, bus fields into regs.
//   Aligned: next state REQ. Misaligned (CHECK_MISALIGN=1): stay IDLE; next cycle lsu_err_o=1 and
//   lsu_done_o=1, no data_req_o.
// - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Byte ops are never misaligned.
// - REQ: data_req_o=1; addr/we/be/wdata are stable until gnt. On gnt -> RVALID. No timeout.
// - RVALID: on data_rvalid_i, register the result, pulse lsu_done_o next cycle, go IDLE.
//   If data_err_i: lsu_err_o=1 and lsu_rdata_o=0.
// - Byte enables: SB/LB/LBU 4'b0001<<addr[1:0]; SH/LH/LHU addr[1] ? 4'b1100 : 4'b0011; W 4'b1111.
// - Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
// - Load data: select byte/half from rdata by captured offset. LB/LH sign-extend; LBU/LHU zero-extend.
// - lsu_busy_o = (state!=IDLE) | (IDLE & lsu_req_i & aligned & op!=NONE). Misaligned accepts do not
//   stall.
// - New request while not IDLE: ignored. The upstream stall guarantees the EX inputs are held.
// - gnt and rvalid in the same cycle as req: still takes REQ then RVALID. rvalid is only sampled in
//   RVALID; the memory delivers rvalid at least 1 cycle after gnt.
// - Latency, zero-wait memory (gnt with req, rvalid next cycle): accept T, req T+1, rvalid T+2,
//   done T+3.
// - Reset mid-transaction: immediate IDLE, data_req_o drops, no done/err pulse.
// STRUCTURE
// - milano_pkg: lsu_opt_e, with LSU_NONE = reset/idle value; lsu_state_e {LSU_IDLE,LSU_REQ,
//   LSU_RVALID}; helper function lsu_be(op, off).
// - Sub-module lsu_data_align: combinational store replicate + load extract/extend, shared by bench
//   models.
// TESTING
// - LW addr 0x100, zero-wait mem returns 0xDEADBEEF -> data_addr_o=0x100, be=4'hF, done at T+3,
//   lsu_rdata_o=0xDEADBEEF.
// - LB addr 0x103, rdata 0x80112233 -> be=4'b1000, rdata_o=0xFFFFFF80; LBU same -> 0x00000080.
// - SH addr 0x202, wdata 0x0000ABCD -> be=4'b1100, data_wdata_o=0xABCDABCD, we=1.
// - gnt delayed 3 cycles -> req/addr/be/wdata stable all 4 cycles, busy held until done.
// - LW addr 0x101 -> no data_req_o, lsu_err_o and lsu_done_o pulse at T+1, busy never asserted.
// - rvalid with data_err_i on LH -> lsu_err_o=1, rdata_o=0. rst_ni low during REQ -> req drops, no
//   pulses.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types and helpers for the milano load/store path.
// The operation encoding keeps LSU_NONE at zero so a reset ID/EX register reads as "no access".
package milano_pkg;

   typedef enum logic [3:0] {
      LSU_NONE = 4'd0,
      LSU_LB   = 4'd1,
      LSU_LH   = 4'd2,
      LSU_LW   = 4'd3,
      LSU_LBU  = 4'd4,
      LSU_LHU  = 4'd5,
      LSU_SB   = 4'd6,
      LSU_SH   = 4'd7,
      LSU_SW   = 4'd8
   } lsu_opt_e;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_REQ    = 2'd1,
      LSU_RVALID = 2'd2
   } lsu_state_e;

   // Byte lanes touched by an access of the given size at the given byte offset
   function automatic logic [3:0] lsu_be(lsu_opt_e op, logic [1:0] off);
      logic [3:0] be;
      case (op)
         LSU_LB, LSU_LBU, LSU_SB: be = 4'b0001 << off;
         LSU_LH, LSU_LHU, LSU_SH: be = off[1] ? 4'b1100 : 4'b0011;
         LSU_LW, LSU_SW:          be = 4'b1111;
         default:                 be = 4'b0000;
      endcase
      return be;
   endfunction

   // Halves must sit on even addresses and words on multiples of four; bytes always fit
   function automatic logic lsu_misaligned(lsu_opt_e op, logic [1:0] off);
      logic mis;
      case (op)
         LSU_LH, LSU_LHU, LSU_SH: mis = off[0];
         LSU_LW, LSU_SW:          mis = (off != 2'b00);
         default:                 mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data steering between the core and the 32-bit memory bus:
// replicates store data across all lanes and extracts/extends load data by byte offset.
module lsu_data_align
   import milano_pkg::*;
(
   input  lsu_opt_e    op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] rdata_shifted;

   // Replicate the store operand so whichever lanes are enabled carry the right bytes
   always_comb begin
      case (op_i)
         LSU_SB:  wdata_o = {4{wdata_i[7:0]}};
         LSU_SH:  wdata_o = {2{wdata_i[15:0]}};
         default: wdata_o = wdata_i;
      endcase
   end

   // Move the addressed byte/half down to bit 0, then sign- or zero-extend by opcode
   always_comb begin
      rdata_shifted = rdata_i >> {off_i, 3'b000};
      case (op_i)
         LSU_LB:  rdata_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         LSU_LBU: rdata_o = {24'h000000, rdata_shifted[7:0]};
         LSU_LH:  rdata_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         LSU_LHU: rdata_o = {16'h0000, rdata_shifted[15:0]};
         LSU_LW:  rdata_o = rdata_i;
         default: rdata_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// EX-stage load/store controller: one req/gnt + rvalid bus transaction per memory instruction,
// with misalignment trapping, byte enables, store replication and load extension.
module lsu_ctrl
   import milano_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter bit CHECK_MISALIGN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  lsu_opt_e          lsu_operate_i,
   input  logic [DATA_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   input  logic [4:0]        lsu_rd_addr_i,
   output logic              data_req_o,
   input  logic              data_gnt_i,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [DATA_W-1:0] data_addr_o,
   output logic [DATA_W-1:0] data_wdata_o,
   input  logic              data_rvalid_i,
   input  logic [DATA_W-1:0] data_rdata_i,
   input  logic              data_err_i,
   output logic              lsu_busy_o,
   output logic              lsu_done_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic [4:0]        lsu_rd_addr_o,
   output logic              lsu_err_o
);

   lsu_state_e        state_q, state_d;
   lsu_opt_e          op_q;
   logic              we_q;
   logic [1:0]        off_q;
   logic [4:0]        rd_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              done_q;
   logic              err_q;
   logic              retire_q;

   logic              accept;
   logic              misaligned;
   logic [DATA_W-1:0] wdata_rep;
   logic [DATA_W-1:0] load_data;

   // A bus transaction's instruction is still sitting in EX during its done cycle, so retire_q
   // keeps it from being accepted a second time; misaligned traps never stall, so they never set it.
   assign accept     = (state_q == LSU_IDLE) && lsu_req_i && (lsu_operate_i != LSU_NONE) && !retire_q;
   assign misaligned = CHECK_MISALIGN && lsu_misaligned(lsu_operate_i, lsu_addr_i[1:0]);

   lsu_data_align u_align (
      .op_i    (op_q),
      .off_i   (off_q),
      .wdata_i (wdata_q),
      .rdata_i (data_rdata_i),
      .wdata_o (wdata_rep),
      .rdata_o (load_data)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= LSU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: every bus access walks REQ -> RVALID -> IDLE; misaligned accepts never leave IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE:   if (accept && !misaligned) state_d = LSU_REQ;
         LSU_REQ:    if (data_gnt_i)            state_d = LSU_RVALID;
         LSU_RVALID: if (data_rvalid_i)         state_d = LSU_IDLE;
         default:                               state_d = LSU_IDLE;
      endcase
   end

   // Bus outputs are driven only while requesting so they idle at zero; busy stalls upstream
   always_comb begin
      data_req_o   = 1'b0;
      data_we_o    = 1'b0;
      data_be_o    = 4'h0;
      data_addr_o  = '0;
      data_wdata_o = '0;
      if (state_q == LSU_REQ) begin
         data_req_o   = 1'b1;
         data_we_o    = we_q;
         data_be_o    = lsu_be(op_q, off_q);
         data_addr_o  = addr_q;
         data_wdata_o = wdata_rep;
      end
      lsu_busy_o = (state_q != LSU_IDLE) || (accept && !misaligned);
   end

   // Capture the request at accept and register the completion pulses and load result
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q     <= LSU_NONE;
         we_q     <= 1'b0;
         off_q    <= 2'b00;
         rd_q     <= 5'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         retire_q <= 1'b0;
         if (accept) begin
            op_q    <= lsu_operate_i;
            we_q    <= lsu_we_i;
            off_q   <= lsu_addr_i[1:0];
            rd_q    <= lsu_rd_addr_i;
            addr_q  <= {lsu_addr_i[DATA_W-1:2], 2'b00};
            wdata_q <= lsu_wdata_i;
            if (misaligned) begin
               done_q  <= 1'b1;
               err_q   <= 1'b1;
               rdata_q <= '0;
            end
         end
         if ((state_q == LSU_RVALID) && data_rvalid_i) begin
            done_q   <= 1'b1;
            err_q    <= data_err_i;
            rdata_q  <= (data_err_i || we_q) ? '0 : load_data;
            retire_q <= 1'b1;
         end
      end
   end

   assign lsu_done_o    = done_q;
   assign lsu_err_o     = err_q;
   assign lsu_rdata_o   = rdata_q;
   assign lsu_rd_addr_o = rd_q;

endmodule
